// File: rtl/ctrl_regs_pkg.sv
// Shared definitions for the compute_wrapper control/status register block:
// register offsets, field bit positions and the AXI response encoding.
package ctrl_regs_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned CFG_K_W = 16;

  localparam logic [3:0] OFF_CTRL    = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_CFG_K   = 4'h8;
  localparam logic [3:0] OFF_VERSION = 4'hC;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STAT_DONE_BIT   = 0;
  localparam int unsigned STAT_BUSY_BIT   = 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

endpackage

// File: rtl/axil_wr_capture.sv
// AXI4-Lite write front end: independent AW/W capture latches and the B handshake.
// Emits a one-cycle commit strobe while both latches are full.
module axil_wr_capture
  import ctrl_regs_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              commit_c,
  output logic [ADDR_W-1:0] cmt_addr,
  output logic [DATA_W-1:0] cmt_data,
  output logic [STRB_W-1:0] cmt_strb,
  input  resp_t             cmt_resp_c
);

  logic aw_held;
  logic w_held;
  logic ready_en;

  // ready_en keeps both readies low while reset is asserted
  assign awready  = ready_en && !aw_held && !bvalid;
  assign wready   = ready_en && !w_held && !bvalid;
  assign commit_c = aw_held && w_held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      cmt_addr <= '0;
      cmt_data <= '0;
      cmt_strb <= '0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
    end else begin
      ready_en <= 1'b1;
      if (awvalid && awready) begin
        aw_held  <= 1'b1;
        cmt_addr <= awaddr;
      end
      if (wvalid && wready) begin
        w_held   <= 1'b1;
        cmt_data <= wdata;
        cmt_strb <= wstrb;
      end
      if (commit_c) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= cmt_resp_c;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite control/status registers for compute_wrapper: START/IRQ_EN, sticky DONE,
// BUSY mirror, CFG_K and a read-only VERSION word.
module axil_ctrl_regs
  import ctrl_regs_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned K_MAX     = 64,
  parameter int unsigned CFG_K_RST = 4,
  parameter logic [31:0] VERSION   = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  s_axil_awaddr,
  input  logic               s_axil_awvalid,
  output logic               s_axil_awready,
  input  logic [31:0]        s_axil_wdata,
  input  logic [3:0]         s_axil_wstrb,
  input  logic               s_axil_wvalid,
  output logic               s_axil_wready,
  output logic [1:0]         s_axil_bresp,
  output logic               s_axil_bvalid,
  input  logic               s_axil_bready,
  input  logic [ADDR_W-1:0]  s_axil_araddr,
  input  logic               s_axil_arvalid,
  output logic               s_axil_arready,
  output logic [31:0]        s_axil_rdata,
  output logic [1:0]         s_axil_rresp,
  output logic               s_axil_rvalid,
  input  logic               s_axil_rready,
  output logic [15:0]        cfg_k,
  output logic               start,
  output logic               sw_clear_done,
  input  logic               done_pulse,
  input  logic               busy,
  output logic               irq
);

  logic                commit_c;
  logic [ADDR_W-1:0]   cmt_addr;
  logic [DATA_W-1:0]   cmt_data;
  logic [STRB_W-1:0]   cmt_strb;
  resp_t               wr_resp_c;
  logic [CFG_K_W-1:0]  cfg_k_new_c;
  logic                cfg_k_we_c;
  logic                irq_en_we_c;
  logic                start_ok_c;
  logic                clr_done_c;
  logic                irq_en;
  logic                done_flag;
  logic                rd_en;
  logic [DATA_W-1:0]   rd_data_c;
  logic                unused_bits;

  assign unused_bits = ^{cmt_addr, s_axil_araddr, cmt_data[31:16], cmt_strb[3:2]};

  axil_wr_capture #(.ADDR_W(ADDR_W)) u_wr_capture (
    .clk        (clk),
    .rst_n      (rst_n),
    .awaddr     (s_axil_awaddr),
    .awvalid    (s_axil_awvalid),
    .awready    (s_axil_awready),
    .wdata      (s_axil_wdata),
    .wstrb      (s_axil_wstrb),
    .wvalid     (s_axil_wvalid),
    .wready     (s_axil_wready),
    .bresp      (s_axil_bresp),
    .bvalid     (s_axil_bvalid),
    .bready     (s_axil_bready),
    .commit_c   (commit_c),
    .cmt_addr   (cmt_addr),
    .cmt_data   (cmt_data),
    .cmt_strb   (cmt_strb),
    .cmt_resp_c (wr_resp_c)
  );

  // Decode the latched write into register enables and the response code
  always_comb begin
    wr_resp_c   = RESP_OKAY;
    cfg_k_we_c  = 1'b0;
    irq_en_we_c = 1'b0;
    start_ok_c  = 1'b0;
    clr_done_c  = 1'b0;
    cfg_k_new_c = cfg_k;
    if (cmt_strb[0]) cfg_k_new_c[7:0]  = cmt_data[7:0];
    if (cmt_strb[1]) cfg_k_new_c[15:8] = cmt_data[15:8];
    case (cmt_addr[3:2])
      OFF_CTRL[3:2]: begin
        if (cmt_strb[0]) begin
          irq_en_we_c = 1'b1;
          if (cmt_data[CTRL_START_BIT]) begin
            if (busy) wr_resp_c  = RESP_SLVERR;
            else      start_ok_c = 1'b1;
          end
        end
      end
      OFF_STATUS[3:2]: begin
        clr_done_c = cmt_strb[0] && cmt_data[STAT_DONE_BIT];
      end
      OFF_CFG_K[3:2]: begin
        if (cfg_k_new_c == '0 || cfg_k_new_c > CFG_K_W'(K_MAX)) wr_resp_c = RESP_SLVERR;
        else cfg_k_we_c = 1'b1;
      end
      default: wr_resp_c = RESP_SLVERR;
    endcase
  end

  // Register state and one-cycle pulses, all aligned with bvalid rising
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_k         <= CFG_K_W'(CFG_K_RST);
      irq_en        <= 1'b0;
      done_flag     <= 1'b0;
      start         <= 1'b0;
      sw_clear_done <= 1'b0;
      irq           <= 1'b0;
    end else begin
      start         <= commit_c && start_ok_c;
      sw_clear_done <= commit_c && clr_done_c;
      if (commit_c && irq_en_we_c) irq_en <= cmt_data[CTRL_IRQ_EN_BIT];
      if (commit_c && cfg_k_we_c)  cfg_k  <= cfg_k_new_c;
      // a completion in the same cycle as a W1C wins
      done_flag     <= done_pulse || (done_flag && !(commit_c && clr_done_c));
      irq           <= done_flag && irq_en;
    end
  end

  always_comb begin
    rd_data_c = '0;
    case (s_axil_araddr[3:2])
      OFF_CTRL[3:2]:   rd_data_c[CTRL_IRQ_EN_BIT] = irq_en;
      OFF_STATUS[3:2]: begin
        rd_data_c[STAT_DONE_BIT] = done_flag;
        rd_data_c[STAT_BUSY_BIT] = busy;
      end
      OFF_CFG_K[3:2]:  rd_data_c = DATA_W'(cfg_k);
      default:         rd_data_c = VERSION;
    endcase
  end

  assign s_axil_arready = rd_en && !s_axil_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en         <= 1'b0;
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= 2'b00;
    end else begin
      rd_en <= 1'b1;
      if (s_axil_arvalid && s_axil_arready) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_data_c;
        s_axil_rresp  <= RESP_OKAY;
      end else if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Directed bench for axil_ctrl_regs; expected B/R responses are queued when a
// transaction is issued and compared when the DUT returns it.
module tb_axil_ctrl_regs;
  import ctrl_regs_pkg::*;

  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [ADDR_W-1:0] araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [15:0]       cfg_k;
  logic              start;
  logic              sw_clear_done;
  logic              done_pulse = 1'b0;
  logic              busy = 1'b0;
  logic              irq;

  int n_assert = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int clr_cnt   = 0;

  logic [1:0]  wr_q[$];
  logic [33:0] rd_q[$];

  axil_ctrl_regs #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .cfg_k          (cfg_k),
    .start          (start),
    .sw_clear_done  (sw_clear_done),
    .done_pulse     (done_pulse),
    .busy           (busy),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start)         start_cnt++;
    if (sw_clear_done) clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input string tag, input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input int aw_dly, input int w_dly, input int b_stall,
                           output logic st_at_b, output logic clr_at_b);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_fire, w_fire, got_b;
    logic [1:0] exp;
    int cyc = 0;
    st_at_b  = 1'b0;
    clr_at_b = 1'b0;
    wr_q.push_back(exp_resp);
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!aw_done && cyc >= aw_dly) begin awaddr = addr; awvalid = 1'b1; end
      if (!w_done && cyc >= w_dly) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      tick();
      if (aw_fire) begin aw_done = 1; awvalid = 1'b0; end
      if (w_fire)  begin w_done = 1;  wvalid = 1'b0; end
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check({tag, "_aw_w_accept"}, 32'(aw_done && w_done), 32'd1);
    got_b = 0;
    for (int i = 0; i < 20 && !got_b; i++) begin
      if (bvalid) got_b = 1;
      else tick();
    end
    check({tag, "_bvalid_seen"}, 32'(got_b), 32'd1);
    exp = wr_q.pop_front();
    if (!got_b) return;
    st_at_b  = start;
    clr_at_b = sw_clear_done;
    check({tag, "_bresp"}, 32'(bresp), 32'(exp));
    for (int i = 0; i < b_stall; i++) begin
      tick();
      check({tag, "_bvalid_hold"}, 32'(bvalid), 32'd1);
      check({tag, "_bresp_hold"}, 32'(bresp), 32'(exp));
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input string tag, input logic [3:0] addr, input logic [31:0] exp_data,
                          input int max_stall);
    bit fire, got;
    logic [33:0] exp;
    logic [31:0] first_data;
    int stall;
    rd_q.push_back({2'b00, exp_data});
    araddr  = addr;
    arvalid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      fire = arready;
      tick();
      if (fire) got = 1;
    end
    arvalid = 1'b0;
    check({tag, "_ar_accept"}, 32'(got), 32'd1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rvalid) got = 1;
      else tick();
    end
    check({tag, "_rvalid_seen"}, 32'(got), 32'd1);
    exp = rd_q.pop_front();
    if (!got) return;
    check({tag, "_rdata"}, rdata, exp[31:0]);
    check({tag, "_rresp"}, 32'(rresp), 32'(exp[33:32]));
    first_data = rdata;
    stall = int'($urandom_range(max_stall, 0));
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_rvalid_hold"}, 32'(rvalid), 32'd1);
      check({tag, "_rdata_hold"}, rdata, first_data);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check({tag, "_single_beat"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    logic st, clr;
    int s0, c0;

    // reset values while rst_n is held low
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_cfg_k",   32'(cfg_k),   32'd4);
    check("rst_start",   32'(start),   32'd0);
    check("rst_clr",     32'(sw_clear_done), 32'd0);
    check("rst_irq",     32'(irq),     32'd0);
    rst_n = 1'b1;
    tick();

    axi_read("rd_status_rst", 4'h4, 32'h0, 0);
    axi_read("rd_ctrl_rst",   4'h0, 32'h0, 0);
    axi_read("rd_cfgk_rst",   4'h8, 32'h4, 0);

    // CFG_K with AW and W together
    axi_write("cfgk_10", 4'h8, 32'h10, 4'hF, 2'b00, 0, 0, 0, st, clr);
    check("cfgk_10_port", 32'(cfg_k), 32'h10);
    axi_read("rd_cfgk_10", 4'h8, 32'h10, 2);

    // W three cycles ahead of AW, illegal value, B stalled
    axi_write("cfgk_41", 4'h8, 32'h41, 4'hF, 2'b10, 3, 0, 4, st, clr);
    check("cfgk_41_port", 32'(cfg_k), 32'h10);

    axi_write("cfgk_strb0", 4'h8, 32'h0000_FF20, 4'b0001, 2'b00, 0, 2, 0, st, clr);
    check("cfgk_strb0_port", 32'(cfg_k), 32'h20);
    axi_write("cfgk_kmax", 4'h8, 32'h40, 4'hF, 2'b00, 0, 0, 0, st, clr);
    check("cfgk_kmax_port", 32'(cfg_k), 32'h40);
    axi_write("cfgk_zero", 4'h8, 32'h0, 4'hF, 2'b10, 0, 0, 1, st, clr);
    check("cfgk_zero_port", 32'(cfg_k), 32'h40);

    // START while idle, then while busy
    s0 = start_cnt;
    axi_write("ctrl_start", 4'h0, 32'h3, 4'hF, 2'b00, 0, 0, 0, st, clr);
    check("ctrl_start_at_b", 32'(st), 32'd1);
    check("ctrl_start_width", 32'(start_cnt - s0), 32'd1);
    axi_read("rd_ctrl_irqen", 4'h0, 32'h2, 1);
    busy = 1'b1;
    tick();
    s0 = start_cnt;
    axi_write("ctrl_busy", 4'h0, 32'h3, 4'hF, 2'b10, 0, 0, 0, st, clr);
    check("ctrl_busy_no_start", 32'(st), 32'd0);
    check("ctrl_busy_cnt", 32'(start_cnt - s0), 32'd0);
    axi_read("rd_status_busy", 4'h4, 32'h2, 0);
    axi_write("ctrl_busy_irqoff", 4'h0, 32'h1, 4'hF, 2'b10, 0, 0, 0, st, clr);
    axi_read("rd_ctrl_irqoff", 4'h0, 32'h0, 0);
    busy = 1'b0;
    axi_write("ctrl_irqon", 4'h0, 32'h2, 4'hF, 2'b00, 0, 0, 0, st, clr);

    // DONE latch, irq lag, W1C
    done_pulse = 1'b1;
    tick();
    done_pulse = 1'b0;
    check("irq_lag", 32'(irq), 32'd0);
    tick();
    check("irq_set", 32'(irq), 32'd1);
    axi_read("rd_status_done", 4'h4, 32'h1, 0);
    repeat (5) tick();
    axi_read("rd_status_sticky", 4'h4, 32'h1, 0);
    check("irq_sticky", 32'(irq), 32'd1);
    c0 = clr_cnt;
    axi_write("status_w1c", 4'h4, 32'h1, 4'hF, 2'b00, 0, 0, 0, st, clr);
    check("w1c_clr_at_b", 32'(clr), 32'd1);
    check("w1c_clr_width", 32'(clr_cnt - c0), 32'd1);
    check("w1c_irq_low", 32'(irq), 32'd0);
    axi_read("rd_status_clr", 4'h4, 32'h0, 0);

    // done_pulse on the same edge the W1C commits
    fork
      axi_write("w1c_race", 4'h4, 32'h1, 4'hF, 2'b00, 0, 0, 0, st, clr);
      begin
        @(posedge clk);
        #1;
        done_pulse = 1'b1;
        @(posedge clk);
        #1;
        done_pulse = 1'b0;
      end
    join
    axi_read("rd_status_race", 4'h4, 32'h1, 0);

    // VERSION read with random R stalls, and rejected write
    axi_read("rd_version", 4'hC, 32'h0001_0000, 5);
    axi_write("wr_version", 4'hC, 32'hDEAD_BEEF, 4'hF, 2'b10, 1, 0, 2, st, clr);
    axi_read("rd_version2", 4'hC, 32'h0001_0000, 5);
    axi_read("rd_cfgk_end", 4'h8, 32'h40, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_ctrl_regs.md
Name: axil_ctrl_regs

Overview:
- AXI4-Lite slave (responder) holding the control/status registers for compute_wrapper.
- Software writes cfg_k, issues START, reads BUSY/DONE, clears DONE (W1C) and enables the interrupt.
- Sits between the host AXI-Lite interconnect and compute_wrapper's start/cfg_k/done_pulse/sw_clear_done/busy pins.
- Replaces the testbench-driven hooks with an architectural register path.

Parameters:
ADDR_W, 4, AXI-Lite address width; byte address, decode uses bits [3:2]
K_MAX, 64, maximum legal CFG_K value
CFG_K_RST, 4, reset value of CFG_K
VERSION, 32'h0001_0000, read-only value of the VERSION register

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_axil_awaddr  in  ADDR_W  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  write byte strobes
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response: 00 OKAY, 10 SLVERR
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_W  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
cfg_k  out  16  K dimension to compute core
start  out  1  one-cycle start pulse to compute core
sw_clear_done  out  1  one-cycle DONE clear pulse to compute core
done_pulse  in  1  one-cycle completion pulse from compute core
busy  in  1  compute core is active
irq  out  1  level interrupt, registered

Behaviour:
- Reset values: all ready/valid outputs 0; bresp and rresp 00; rdata 0; cfg_k = CFG_K_RST; start, sw_clear_done, irq 0; IRQ_EN 0; DONE 0.
- Register map (byte addresses):
  - 0x0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (RW).
  - 0x4 STATUS: bit0 DONE (sticky, W1C); bit1 BUSY (RO, mirrors busy).
  - 0x8 CFG_K: [15:0] RW.
  - 0xC VERSION: RO.
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW and W are accepted independently, in any order or in the same cycle, and latched.
  - On the edge after both latches are full, the write commits: the register updates, bvalid=1, and both latches clear.
  - bvalid holds with a stable bresp until bready; no new AW/W is accepted while bvalid=1.
- Write rules:
  - wstrb lane 0 gates CTRL and STATUS; lanes 0-1 gate CFG_K bytes.
  - CFG_K write whose resulting value is 0 or > K_MAX: SLVERR, cfg_k unchanged.
  - START=1 while busy=1: SLVERR, no pulse; IRQ_EN in the same write still updates.
  - Writes to VERSION: SLVERR, no effect.
  - All other writes: OKAY.
- start and sw_clear_done:
  - start is high exactly one cycle, coincident with bvalid rising.
  - sw_clear_done is high for one cycle on a STATUS write with bit0=1.
- DONE latch:
  - Set by done_pulse; cleared by W1C.
  - done_pulse and W1C in the same cycle: set wins, DONE stays 1.
- irq is registered: irq = DONE && IRQ_EN, one cycle after either input changes.
- Read channel:
  - arready = !rvalid.
  - On the AR handshake, rdata/rresp are registered and rvalid=1 on the next edge.
  - rdata and rresp are held until rready; one read outstanding at a time.
  - STATUS read returns the live DONE/BUSY at the AR handshake cycle.
  - Reads never error; unused bits read 0.
- Reads and writes are fully independent; a simultaneous read and write to the same register returns the pre-write value.
- Reset mid-transaction: latches drop and valids deassert immediately (async); the master must restart the transaction.

Decomposition:
- Package ctrl_regs_pkg:
  - register offset localparams (CTRL/STATUS/CFG_K/VERSION);
  - bit-index localparams;
  - resp_t enum (OKAY, SLVERR).
- Sub-module axil_wr_capture: AW/W independent capture latches plus the B-response handshake; emits a one-cycle commit strobe with addr/data/strb.

Test Plan:
- Write CFG_K=0x10 with AW and W in the same cycle → bresp OKAY; cfg_k=16; read 0x8 returns 0x10.
- W sent 3 cycles before AW, then CFG_K=0x41 → bresp SLVERR, cfg_k unchanged at 16; bready held low 4 cycles → bvalid and bresp stable throughout.
- Write CTRL=0x3 with busy=0 → start high for exactly 1 cycle, IRQ_EN=1; repeat with busy=1 → SLVERR, no start pulse.
- done_pulse → STATUS reads 0x1, irq=1 one cycle later; five idle cycles → DONE still 1; write STATUS=0x1 → sw_clear_done pulses, DONE=0, irq=0.
- done_pulse in the same cycle as a W1C commit → DONE remains 1.
- Read VERSION with rready stalled randomly → rdata 0x0001_0000, rresp OKAY, single beat; write to 0xC → SLVERR.
